airi5c_lsu: RTL and testbench
=============================

Name: airi5c_lsu

Overview:
- Load/store unit fed by the EX pipeline registers: consumes the registered memory request (enable, write, size, address, store data) and runs a single-outstanding AHB-Lite data-memory transfer.
- Stalls EX until the transfer completes.
- Returns the aligned, sign/zero-extended load word and exception pulses toward WB/CSR one cycle after completion.
- Detects misalignment before any bus activity.

Parameters:
- XPR_LEN, 32, data/address width (only 32 supported).

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous active-high reset
- dmem_en_i  in  1  memory request from EX (unkilled)
- dmem_wen_i  in  1  1 = store, 0 = load
- dmem_size_i  in  3  funct3 encoding: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU
- addr_i  in  32  effective address from ALU
- wdata_i  in  32  store data (rs2)
- killed_ex_i  in  1  EX instruction killed this cycle
- dmem_haddr_o  out  32  AHB address
- dmem_hwrite_o  out  1  AHB write
- dmem_hsize_o  out  3  AHB size = {1'b0, dmem_size_i[1:0]}
- dmem_htrans_o  out  2  IDLE = 2'b00, NONSEQ = 2'b10
- dmem_hwdata_o  out  32  AHB write data (data phase)
- dmem_hrdata_i  in  32  AHB read data
- dmem_hready_i  in  1  AHB ready
- dmem_hresp_i  in  1  AHB error response
- stall_o  out  1  hold EX
- load_data_o  out  32  formatted load result (registered)
- load_valid_o  out  1  one-cycle pulse, load_data_o updated
- misaligned_load_o  out  1  combinational, request cycle
- misaligned_store_o  out  1  combinational, request cycle
- bus_error_o  out  1  one-cycle registered pulse

Behaviour:
- Reset (async, rst_i = 1): state IDLE; htrans IDLE; haddr 0; hwrite 0; hsize 3'h2; hwdata 0; load_data_o 0; all pulses and stall_o 0. Reset mid-transfer drops the transfer immediately.
- Misaligned: H/HU with addr_i[0] = 1, or W with addr_i[1:0] != 0.
  - misaligned_load_o / misaligned_store_o = dmem_en_i & ~killed_ex_i & misaligned & ~/dmem_wen_i.
  - No bus transfer, no stall.
- req = dmem_en_i & ~killed_ex_i & ~misaligned, sampled only in IDLE.
- States: IDLE, ADDR, DATA.
- IDLE:
  - No req: htrans = IDLE.
  - req: drive NONSEQ with haddr = addr_i, hwrite, hsize (combinational); stall_o = 1.
  - Capture addr[1:0], size, wen and lane-replicated store data.
  - hready_i = 1 → DATA; else → ADDR.
- ADDR: re-drive the captured address phase (stable per AHB); stall_o = 1; hready_i = 1 → DATA.
- DATA: htrans = IDLE; hwdata = captured replicated data; stall_o = ~dmem_hready_i.
  - hready & ~hresp → completion → IDLE.
  - hready & hresp (second error cycle) → IDLE, bus_error_o pulses next cycle.
  - hresp with ~hready (first error cycle): remain, stall.
- Completion latency: stall_o falls in the completion cycle.
  - Load: load_data_o registered at that edge; load_valid_o = 1 the following cycle only.
  - Store: no valid pulse.
  - Minimum load = 2 cycles of stall (IDLE accept, DATA with hready).
- Store lane replication: B → {4{wdata[7:0]}}; H → {2{wdata[15:0]}}; W as is.
- Load formatting: byte at lane addr[1:0], half at addr[1]. Sign-extend for size 0/1, zero-extend for 4/5. load_data_o holds until the next load completes.
- killed_ex_i while in ADDR/DATA: the transfer is not aborted (AHB rule). A drop flag is set; load_valid_o, load_data_o update and bus_error_o are suppressed for that transfer.
- dmem_size_i codes 3, 6, 7: treated as W for size/alignment (decoder guarantees they never occur).
- Back-to-back: a new request is accepted only in IDLE, i.e. the cycle after completion; no address/data pipelining.

Decomposition:
- Shared header, next to the ctrl constants:
  - MEM size codes (MEM_SIZE_B/H/W/BU/HU)
  - HTRANS_IDLE/NONSEQ
  - LSU state encoding (2 bits)
- Sub-module airi5c_lsu_fmt (purely combinational): store-lane replication and load extract/extend, shared with any future debug memory path.

Test Plan:
- LW addr 0x100, hrdata 0xDEADBEEF, hready always 1 → NONSEQ cycle 0, stall 2 cycles, load_valid next cycle, load_data 0xDEADBEEF.
- LB addr 0x103, hrdata 0x80FF_0000 → 0xFFFFFF80; LBU same → 0x00000080; LHU addr 0x102 → 0x000080FF.
- SB addr 0x201, wdata 0x12345678 → hsize 0, hwrite 1, hwdata 0x78787878; no load_valid.
- LW addr 0x102 → misaligned_load_o = 1 same cycle, htrans stays IDLE, stall 0; SH addr 0x001 → misaligned_store_o = 1.
- Wait states: hready low 1 cycle in address phase, then 3 cycles in data phase → haddr stable throughout, stall 6 cycles, single load_valid.
- Error: data phase hresp = 1/hready = 0 then hresp = 1/hready = 1 → bus_error_o 1-cycle pulse, no load_valid. Repeat with killed_ex_i during the wait → no pulse. Assert rst_i mid-DATA → htrans IDLE and stall 0 immediately.

Source files
------------

// File: rtl/airi5c_lsu_pkg.sv
// Shared constants for the AIRI5C load/store unit.
//   - MEM_SIZE_*  : funct3 memory size codes as delivered by the decoder
//   - HTRANS_*    : AHB-Lite transfer types used by the LSU
//   - lsu_state_t : 2-bit LSU transfer state encoding
//   - ahb_size()  : funct3 size -> AHB HSIZE (unused codes fold to word)
//   - is_misaligned() : alignment check for a size/low-address pair
package airi5c_lsu_pkg;

    localparam logic [2:0] MEM_SIZE_B  = 3'd0;
    localparam logic [2:0] MEM_SIZE_H  = 3'd1;
    localparam logic [2:0] MEM_SIZE_W  = 3'd2;
    localparam logic [2:0] MEM_SIZE_BU = 3'd4;
    localparam logic [2:0] MEM_SIZE_HU = 3'd5;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_ADDR = 2'd1,
        LSU_DATA = 2'd2
    } lsu_state_t;

    // Only the low two bits select the access width; bit 2 is signedness.
    // Codes 3/6/7 never come from the decoder and are treated as word.
    function automatic logic [2:0] ahb_size(input logic [2:0] size);
        case (size[1:0])
            2'd0:    return 3'd0;
            2'd1:    return 3'd1;
            default: return 3'd2;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size[1:0])
            2'd0:    return 1'b0;
            2'd1:    return addr_lo[0];
            default: return |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/airi5c_lsu_fmt.sv
// Data formatting for the load/store unit (purely combinational).
//   st_size_i / st_data_i -> st_data_o : store data replicated onto all byte lanes
//   ld_size_i / ld_addr_i / ld_data_i -> ld_data_o : load lane extraction plus
//                                        sign (B/H) or zero (BU/HU) extension
module airi5c_lsu_fmt
    import airi5c_lsu_pkg::*;
(
    input  logic [2:0]  st_size_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] st_data_o,
    input  logic [2:0]  ld_size_i,
    input  logic [1:0]  ld_addr_i,
    input  logic [31:0] ld_data_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_signed;

    // Replicating the store data means the slave picks the right lane from
    // HADDR/HSIZE alone; no byte-strobe logic is needed on this side.
    always_comb begin
        case (st_size_i[1:0])
            2'd0:    st_data_o = {4{st_data_i[7:0]}};
            2'd1:    st_data_o = {2{st_data_i[15:0]}};
            default: st_data_o = st_data_i;
        endcase
    end

    always_comb begin
        case (ld_addr_i)
            2'd0:    ld_byte = ld_data_i[7:0];
            2'd1:    ld_byte = ld_data_i[15:8];
            2'd2:    ld_byte = ld_data_i[23:16];
            default: ld_byte = ld_data_i[31:24];
        endcase
    end

    assign ld_half   = ld_addr_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];
    assign ld_signed = ~ld_size_i[2];

    always_comb begin
        case (ld_size_i[1:0])
            2'd0:    ld_data_o = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            2'd1:    ld_data_o = {{16{ld_signed & ld_half[15]}}, ld_half};
            default: ld_data_o = ld_data_i;
        endcase
    end

endmodule

// File: rtl/airi5c_lsu.sv
// AIRI5C load/store unit: single-outstanding AHB-Lite data-memory master.
//   clk_i, rst_i           : core clock, asynchronous active-high reset
//   dmem_*_i, addr_i,
//   wdata_i, killed_ex_i   : registered memory request from EX
//   dmem_h*_o / dmem_h*_i  : AHB-Lite master interface
//   stall_o                : holds EX while a transfer is in flight
//   load_data_o/valid_o    : formatted load result, valid pulse the cycle
//                            after completion
//   misaligned_*_o         : combinational, in the request cycle, no bus access
//   bus_error_o            : one-cycle pulse after an AHB error response
module airi5c_lsu
    import airi5c_lsu_pkg::*;
#(
    parameter int XPR_LEN = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               dmem_en_i,
    input  logic               dmem_wen_i,
    input  logic [2:0]         dmem_size_i,
    input  logic [XPR_LEN-1:0] addr_i,
    input  logic [XPR_LEN-1:0] wdata_i,
    input  logic               killed_ex_i,
    output logic [XPR_LEN-1:0] dmem_haddr_o,
    output logic               dmem_hwrite_o,
    output logic [2:0]         dmem_hsize_o,
    output logic [1:0]         dmem_htrans_o,
    output logic [XPR_LEN-1:0] dmem_hwdata_o,
    input  logic [XPR_LEN-1:0] dmem_hrdata_i,
    input  logic               dmem_hready_i,
    input  logic               dmem_hresp_i,
    output logic               stall_o,
    output logic [XPR_LEN-1:0] load_data_o,
    output logic               load_valid_o,
    output logic               misaligned_load_o,
    output logic               misaligned_store_o,
    output logic               bus_error_o
);

    lsu_state_t         state_q;
    logic [XPR_LEN-1:0] haddr_q;
    logic               hwrite_q;
    logic [2:0]         hsize_q;
    logic [2:0]         size_q;
    logic [XPR_LEN-1:0] wdata_q;
    logic               drop_q;
    logic [XPR_LEN-1:0] load_data_q;
    logic               load_valid_q;
    logic               bus_error_q;

    logic               misaligned;
    logic               req_live;
    logic               req;
    logic               drop_eff;
    logic [XPR_LEN-1:0] wdata_rep;
    logic [XPR_LEN-1:0] rdata_fmt;

    assign misaligned         = is_misaligned(dmem_size_i, addr_i[1:0]);
    assign req_live           = dmem_en_i & ~killed_ex_i;
    assign misaligned_load_o  = req_live & misaligned & ~dmem_wen_i;
    assign misaligned_store_o = req_live & misaligned &  dmem_wen_i;

    // Gating with rst_i keeps the address phase and stall quiet while reset
    // is held, even though EX may still present its request.
    assign req = req_live & ~misaligned & ~rst_i & (state_q == LSU_IDLE);

    // A kill arriving in the same cycle as the response still suppresses it.
    assign drop_eff = drop_q | killed_ex_i;

    airi5c_lsu_fmt u_fmt (
        .st_size_i (dmem_size_i),
        .st_data_i (wdata_i),
        .st_data_o (wdata_rep),
        .ld_size_i (size_q),
        .ld_addr_i (haddr_q[1:0]),
        .ld_data_i (dmem_hrdata_i),
        .ld_data_o (rdata_fmt)
    );

    // The first address phase is driven straight from EX so a load costs only
    // one extra cycle; later cycles replay the captured copy.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        dmem_htrans_o = HTRANS_IDLE;
        dmem_haddr_o  = haddr_q;
        dmem_hwrite_o = hwrite_q;
        dmem_hsize_o  = hsize_q;
        stall_o       = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (req) begin
                    dmem_htrans_o = HTRANS_NONSEQ;
                    dmem_haddr_o  = addr_i;
                    dmem_hwrite_o = dmem_wen_i;
                    dmem_hsize_o  = ahb_size(dmem_size_i);
                    stall_o       = 1'b1;
                end
            end
            LSU_ADDR: begin
                dmem_htrans_o = HTRANS_NONSEQ;
                stall_o       = 1'b1;
            end
            LSU_DATA: begin
                stall_o = ~dmem_hready_i;
            end
            default: ;
        endcase
    end

    assign dmem_hwdata_o = wdata_q;
    assign load_data_o   = load_data_q;
    assign load_valid_o  = load_valid_q;
    assign bus_error_o   = bus_error_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= LSU_IDLE;
            haddr_q      <= '0;
            hwrite_q     <= 1'b0;
            hsize_q      <= 3'h2;
            size_q       <= MEM_SIZE_W;
            wdata_q      <= '0;
            drop_q       <= 1'b0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            bus_error_q  <= 1'b0;
            case (state_q)
                LSU_IDLE: begin
                    if (req) begin
                        haddr_q  <= addr_i;
                        hwrite_q <= dmem_wen_i;
                        hsize_q  <= ahb_size(dmem_size_i);
                        size_q   <= dmem_size_i;
                        wdata_q  <= wdata_rep;
                        drop_q   <= 1'b0;
                        state_q  <= dmem_hready_i ? LSU_DATA : LSU_ADDR;
                    end
                end
                LSU_ADDR: begin
                    // An accepted AHB transfer cannot be withdrawn; a kill only
                    // discards its result.
                    if (killed_ex_i) drop_q <= 1'b1;
                    if (dmem_hready_i) state_q <= LSU_DATA;
                end
                LSU_DATA: begin
                    if (killed_ex_i) drop_q <= 1'b1;
                    // hresp with hready low is the first error cycle: keep waiting.
                    if (dmem_hready_i) begin
                        state_q <= LSU_IDLE;
                        if (dmem_hresp_i) begin
                            bus_error_q <= ~drop_eff;
                        end else if (!hwrite_q && !drop_eff) begin
                            load_data_q  <= rdata_fmt;
                            load_valid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_airi5c_lsu.sv
// Directed self-checking bench for airi5c_lsu. Inputs change 1 ns after the
// rising edge; outputs are sampled 3 ns after the edge, mid-cycle.
module tb_airi5c_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        dmem_en_i;
    logic        dmem_wen_i;
    logic [2:0]  dmem_size_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        killed_ex_i;
    logic [31:0] dmem_haddr_o;
    logic        dmem_hwrite_o;
    logic [2:0]  dmem_hsize_o;
    logic [1:0]  dmem_htrans_o;
    logic [31:0] dmem_hwdata_o;
    logic [31:0] dmem_hrdata_i;
    logic        dmem_hready_i;
    logic        dmem_hresp_i;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic        misaligned_load_o;
    logic        misaligned_store_o;
    logic        bus_error_o;

    int vectors     = 0;
    int miscompares = 0;
    int stall_count;

    airi5c_lsu #(.XPR_LEN(32)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .dmem_en_i          (dmem_en_i),
        .dmem_wen_i         (dmem_wen_i),
        .dmem_size_i        (dmem_size_i),
        .addr_i             (addr_i),
        .wdata_i            (wdata_i),
        .killed_ex_i        (killed_ex_i),
        .dmem_haddr_o       (dmem_haddr_o),
        .dmem_hwrite_o      (dmem_hwrite_o),
        .dmem_hsize_o       (dmem_hsize_o),
        .dmem_htrans_o      (dmem_htrans_o),
        .dmem_hwdata_o      (dmem_hwdata_o),
        .dmem_hrdata_i      (dmem_hrdata_i),
        .dmem_hready_i      (dmem_hready_i),
        .dmem_hresp_i       (dmem_hresp_i),
        .stall_o            (stall_o),
        .load_data_o        (load_data_o),
        .load_valid_o       (load_valid_o),
        .misaligned_load_o  (misaligned_load_o),
        .misaligned_store_o (misaligned_store_o),
        .bus_error_o        (bus_error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic quiet_inputs();
        dmem_en_i     = 1'b0;
        dmem_wen_i    = 1'b0;
        killed_ex_i   = 1'b0;
        dmem_hready_i = 1'b1;
        dmem_hresp_i  = 1'b0;
        dmem_hrdata_i = 32'h0;
    endtask

    // Zero-wait-state load: accept cycle (stall high), completion cycle
    // (stall low), result cycle (valid pulse), then valid must be gone.
    task automatic simple_load(input string tag, input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] rdata, input logic [2:0] exp_hsize,
                               input logic [31:0] exp_data);
        tick();
        dmem_en_i = 1'b1; dmem_wen_i = 1'b0; dmem_size_i = size; addr_i = addr;
        dmem_hready_i = 1'b1; dmem_hresp_i = 1'b0; dmem_hrdata_i = 32'h0;
        settle();
        check({tag, " htrans accept"}, 32'(dmem_htrans_o), 32'h2);
        check({tag, " haddr"},         dmem_haddr_o,       addr);
        check({tag, " hsize"},         32'(dmem_hsize_o),  32'(exp_hsize));
        check({tag, " hwrite"},        32'(dmem_hwrite_o), 32'h0);
        check({tag, " stall accept"},  32'(stall_o),       32'h1);
        tick();
        dmem_hrdata_i = rdata;
        settle();
        check({tag, " htrans data"},   32'(dmem_htrans_o), 32'h0);
        check({tag, " stall data"},    32'(stall_o),       32'h0);
        check({tag, " valid early"},   32'(load_valid_o),  32'h0);
        tick();
        quiet_inputs();
        settle();
        check({tag, " load_valid"},    32'(load_valid_o),  32'h1);
        check({tag, " load_data"},     load_data_o,        exp_data);
        tick();
        settle();
        check({tag, " valid once"},    32'(load_valid_o),  32'h0);
        check({tag, " data held"},     load_data_o,        exp_data);
    endtask

    task automatic simple_store(input string tag, input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_hwdata,
                                input logic [31:0] held_load);
        tick();
        dmem_en_i = 1'b1; dmem_wen_i = 1'b1; dmem_size_i = size; addr_i = addr; wdata_i = wdata;
        dmem_hready_i = 1'b1;
        settle();
        check({tag, " htrans"}, 32'(dmem_htrans_o), 32'h2);
        check({tag, " hwrite"}, 32'(dmem_hwrite_o), 32'h1);
        check({tag, " hsize"},  32'(dmem_hsize_o),  32'(size));
        check({tag, " haddr"},  dmem_haddr_o,       addr);
        check({tag, " stall"},  32'(stall_o),       32'h1);
        tick();
        settle();
        check({tag, " hwdata"},     dmem_hwdata_o,      exp_hwdata);
        check({tag, " htrans data"}, 32'(dmem_htrans_o), 32'h0);
        check({tag, " stall data"}, 32'(stall_o),       32'h0);
        tick();
        quiet_inputs();
        settle();
        check({tag, " no valid"},   32'(load_valid_o),  32'h0);
        check({tag, " data held"},  load_data_o,        held_load);
    endtask

    initial begin
        rst_i       = 1'b1;
        dmem_size_i = 3'd0;
        addr_i      = 32'h0;
        wdata_i     = 32'h0;
        quiet_inputs();

        // Reset state
        #12;
        check("rst htrans",     32'(dmem_htrans_o), 32'h0);
        check("rst haddr",      dmem_haddr_o,       32'h0);
        check("rst hwrite",     32'(dmem_hwrite_o), 32'h0);
        check("rst hsize",      32'(dmem_hsize_o),  32'h2);
        check("rst hwdata",     dmem_hwdata_o,      32'h0);
        check("rst load_data",  load_data_o,        32'h0);
        check("rst stall",      32'(stall_o),       32'h0);
        check("rst load_valid", 32'(load_valid_o),  32'h0);
        check("rst bus_error",  32'(bus_error_o),   32'h0);
        tick();
        rst_i = 1'b0;

        // Basic loads: word, signed/unsigned byte at lane 3, halves
        simple_load("LW 100",  3'd2, 32'h100, 32'hDEADBEEF, 3'd2, 32'hDEADBEEF);
        simple_load("LB 103",  3'd0, 32'h103, 32'h80FF0000, 3'd0, 32'hFFFFFF80);
        simple_load("LBU 103", 3'd4, 32'h103, 32'h80FF0000, 3'd0, 32'h00000080);
        simple_load("LHU 102", 3'd5, 32'h102, 32'h80FF0000, 3'd1, 32'h000080FF);
        simple_load("LH 102",  3'd1, 32'h102, 32'h80FF0000, 3'd1, 32'hFFFF80FF);
        simple_load("LB 101",  3'd0, 32'h101, 32'h12345678, 3'd0, 32'h00000056);

        // Stores: lane replication, no load result
        simple_store("SB 201", 3'd0, 32'h201, 32'h12345678, 32'h78787878, 32'h00000056);
        simple_store("SH 202", 3'd1, 32'h202, 32'hAABBCCDD, 32'hCCDDCCDD, 32'h00000056);
        simple_store("SW 204", 3'd2, 32'h204, 32'hCAFEF00D, 32'hCAFEF00D, 32'h00000056);

        // Misalignment: flagged in the request cycle, no bus activity, no stall
        tick();
        dmem_en_i = 1'b1; dmem_wen_i = 1'b0; dmem_size_i = 3'd2; addr_i = 32'h102;
        settle();
        check("LW 102 mis_load",  32'(misaligned_load_o),  32'h1);
        check("LW 102 mis_store", 32'(misaligned_store_o), 32'h0);
        check("LW 102 htrans",    32'(dmem_htrans_o),      32'h0);
        check("LW 102 stall",     32'(stall_o),            32'h0);
        tick();
        dmem_wen_i = 1'b1; dmem_size_i = 3'd1; addr_i = 32'h001;
        settle();
        check("SH 001 mis_store", 32'(misaligned_store_o), 32'h1);
        check("SH 001 mis_load",  32'(misaligned_load_o),  32'h0);
        check("SH 001 htrans",    32'(dmem_htrans_o),      32'h0);
        check("SH 001 stall",     32'(stall_o),            32'h0);
        tick();
        dmem_wen_i = 1'b0; dmem_size_i = 3'd5; addr_i = 32'h103;
        settle();
        check("LHU 103 mis_load", 32'(misaligned_load_o),  32'h1);
        tick();
        killed_ex_i = 1'b1;
        settle();
        check("killed mis_load",  32'(misaligned_load_o),  32'h0);
        check("killed htrans",    32'(dmem_htrans_o),      32'h0);
        tick();
        quiet_inputs();
        dmem_size_i = 3'd0; addr_i = 32'h103;
        dmem_en_i = 1'b1;
        settle();
        check("LB 103 aligned",   32'(misaligned_load_o),  32'h0);
        dmem_en_i = 1'b0;
        settle();

        // Wait states: one in the address phase, three in the data phase.
        // Six cycles in EX: stall high for five, low in the completion cycle.
        stall_count = 0;
        tick();
        dmem_en_i = 1'b1; dmem_wen_i = 1'b0; dmem_size_i = 3'd2; addr_i = 32'h300;
        dmem_hready_i = 1'b0;
        settle();
        check("WS c0 htrans", 32'(dmem_htrans_o), 32'h2);
        check("WS c0 haddr",  dmem_haddr_o,       32'h300);
        if (stall_o === 1'b1) stall_count++;
        tick();
        dmem_hready_i = 1'b1;
        addr_i = 32'h0;  // address phase must come from the captured copy
        settle();
        check("WS c1 htrans", 32'(dmem_htrans_o), 32'h2);
        check("WS c1 haddr",  dmem_haddr_o,       32'h300);
        if (stall_o === 1'b1) stall_count++;
        for (int i = 0; i < 3; i++) begin
            tick();
            dmem_hready_i = 1'b0;
            settle();
            check("WS data htrans", 32'(dmem_htrans_o), 32'h0);
            check("WS data haddr",  dmem_haddr_o,       32'h300);
            check("WS data stall",  32'(stall_o),       32'h1);
            if (stall_o === 1'b1) stall_count++;
        end
        tick();
        dmem_hready_i = 1'b1; dmem_hrdata_i = 32'h0BADF00D;
        settle();
        check("WS done stall", 32'(stall_o), 32'h0);
        if (stall_o === 1'b1) stall_count++;
        check("WS stall cycles", 32'(stall_count), 32'd5);
        tick();
        quiet_inputs();
        settle();
        check("WS load_valid", 32'(load_valid_o), 32'h1);
        check("WS load_data",  load_data_o,       32'h0BADF00D);
        tick();
        settle();
        check("WS valid once", 32'(load_valid_o), 32'h0);

        // Two-cycle error response
        tick();
        dmem_en_i = 1'b1; dmem_wen_i = 1'b0; dmem_size_i = 3'd2; addr_i = 32'h400;
        settle();
        check("ERR accept", 32'(dmem_htrans_o), 32'h2);
        tick();
        dmem_hresp_i = 1'b1; dmem_hready_i = 1'b0;
        settle();
        check("ERR c1 stall",  32'(stall_o),     32'h1);
        check("ERR c1 no err", 32'(bus_error_o), 32'h0);
        tick();
        dmem_hready_i = 1'b1;
        settle();
        check("ERR c2 stall",  32'(stall_o),     32'h0);
        tick();
        quiet_inputs();
        settle();
        check("ERR pulse",     32'(bus_error_o),  32'h1);
        check("ERR no valid",  32'(load_valid_o), 32'h0);
        check("ERR data held", load_data_o,       32'h0BADF00D);
        tick();
        settle();
        check("ERR pulse once", 32'(bus_error_o), 32'h0);

        // Same error with the instruction killed during the wait: no pulse
        tick();
        dmem_en_i = 1'b1; dmem_wen_i = 1'b0; dmem_size_i = 3'd2; addr_i = 32'h404;
        settle();
        tick();
        dmem_hresp_i = 1'b1; dmem_hready_i = 1'b0; killed_ex_i = 1'b1;
        settle();
        check("KERR c1 htrans", 32'(dmem_htrans_o), 32'h0);
        tick();
        killed_ex_i = 1'b0; dmem_hready_i = 1'b1;
        settle();
        check("KERR c2 stall", 32'(stall_o), 32'h0);
        tick();
        quiet_inputs();
        settle();
        check("KERR no pulse", 32'(bus_error_o),  32'h0);
        check("KERR no valid", 32'(load_valid_o), 32'h0);

        // Killed load: bus transfer finishes, result is discarded
        tick();
        dmem_en_i = 1'b1; dmem_wen_i = 1'b0; dmem_size_i = 3'd2; addr_i = 32'h408;
        settle();
        tick();
        dmem_hready_i = 1'b0; killed_ex_i = 1'b1;
        settle();
        check("KLD c1 stall", 32'(stall_o), 32'h1);
        tick();
        killed_ex_i = 1'b0; dmem_hready_i = 1'b1; dmem_hrdata_i = 32'hFFFFFFFF;
        settle();
        check("KLD c2 stall", 32'(stall_o), 32'h0);
        tick();
        quiet_inputs();
        settle();
        check("KLD no valid",  32'(load_valid_o), 32'h0);
        check("KLD data held", load_data_o,       32'h0BADF00D);

        // Reset asserted in the data phase drops the transfer at once
        tick();
        dmem_en_i = 1'b1; dmem_wen_i = 1'b0; dmem_size_i = 3'd2; addr_i = 32'h500;
        settle();
        tick();
        dmem_hready_i = 1'b0;
        settle();
        check("RST pre stall", 32'(stall_o), 32'h1);
        rst_i = 1'b1;
        #1;
        check("RST htrans",    32'(dmem_htrans_o), 32'h0);
        check("RST stall",     32'(stall_o),       32'h0);
        check("RST load_data", load_data_o,        32'h0);
        check("RST haddr",     dmem_haddr_o,       32'h0);
        tick();
        rst_i = 1'b0;
        quiet_inputs();
        settle();
        check("RST idle htrans", 32'(dmem_htrans_o), 32'h0);
        check("RST idle stall",  32'(stall_o),       32'h0);

        // Recovery after reset
        simple_load("LW post-rst", 3'd2, 32'h600, 32'h13579BDF, 3'd2, 32'h13579BDF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
